// File: rtl/instr_mem_ctrl_if.sv
// Load-stream and fetch-port bundle for instr_mem_ctrl.
// The slave modport is the memory side; the master modport is the loader/fetch side.
interface instr_mem_ctrl_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 1024
);
    logic                     ld_start;
    logic                     ld_valid;
    logic [INSTR_W-1:0]       ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    logic                     ld_ovf;
    logic [$clog2(DEPTH):0]   loaded_words;

    logic                     req_valid;
    logic [ADDR_W-1:0]        req_addr;
    logic                     req_ready;
    logic                     resp_valid;
    logic [INSTR_W-1:0]       resp_instr;
    logic                     resp_err;
    logic                     resp_ready;

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, req_valid, req_addr, resp_ready,
        output ld_ready, ld_ovf, loaded_words, req_ready, resp_valid, resp_instr, resp_err
    );

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, req_valid, req_addr, resp_ready,
        input  ld_ready, ld_ovf, loaded_words, req_ready, resp_valid, resp_instr, resp_err
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: streaming program load (LOAD state), then one-cycle-latency
// valid/ready fetch (RUN state) with misalignment / out-of-range error responses.
module instr_mem_ctrl #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 1024,
    parameter int                 BYTE_ADDR = 1,
    parameter logic [INSTR_W-1:0] NOP       = INSTR_W'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    instr_mem_ctrl_if.slave  bus,
    output logic [0:0]       dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int SHIFT = (BYTE_ADDR != 0) ? $clog2(INSTR_W / 8) : 0;
    localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state;
    logic [CNT_W-1:0]    ptr;
    logic                ovf;
    logic [INSTR_W-1:0]  mem [DEPTH];

    logic                resp_valid_q;
    logic [INSTR_W-1:0]  resp_instr_q;
    logic                resp_err_q;

    logic [ADDR_W-1:0]   word_idx;
    logic                req_err;
    logic                req_rdy;
    logic                accept;
    logic                ld_take;
    logic                ptr_room;

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
    // Ready never depends on valid; the response register holds steady until resp_ready.
    assign word_idx = bus.req_addr >> SHIFT;
    assign req_err  = ((bus.req_addr & OFF_MASK) != '0) || (word_idx >= ADDR_W'(DEPTH));
    assign req_rdy  = (state == S_RUN) && (!resp_valid_q || bus.resp_ready);
    assign accept   = bus.req_valid && req_rdy;
    assign ptr_room = ptr < CNT_W'(DEPTH);
    // ld_start wins over a concurrent load word, which is then dropped entirely.
    assign ld_take  = (state == S_LOAD) && !bus.ld_start && bus.ld_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
            ptr   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.ld_start) begin
                        ptr <= '0;
                        ovf <= 1'b0;
                    end else if (bus.ld_valid) begin
                        if (ptr_room) ptr <= ptr + CNT_W'(1);
                        else          ovf <= 1'b1;
                        if (bus.ld_last) state <= S_RUN;
                    end
                end
                default: begin
                    if (bus.ld_start) begin
                        state <= S_LOAD;
                        ptr   <= '0;
                        ovf   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Contents survive reset and reloads; only written words are defined.
    always_ff @(posedge clk) begin
        if (ld_take && ptr_room) mem[ptr[IDX_W-1:0]] <= bus.ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= req_err;
            resp_instr_q <= req_err ? NOP : mem[word_idx[IDX_W-1:0]];
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.ld_ready     = (state == S_LOAD);
    assign bus.ld_ovf       = ovf;
    assign bus.loaded_words = ptr;
    assign bus.req_ready    = req_rdy;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_instr   = resp_instr_q;
    assign bus.resp_err     = resp_err_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: two instances (1024 words byte-addressed, 4 words word-addressed)
// stepped in lockstep against a per-cycle reference model with an expected-response queue.
module tb_instr_mem_ctrl;
  localparam int W = 34;                 // {checkable, err, instr}
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // driven inputs, one slot per instance
  logic        ld_start_v [2];
  logic        ld_valid_v [2];
  logic        ld_last_v  [2];
  logic [31:0] ld_data_v  [2];
  logic        req_valid_v[2];
  logic [63:0] req_addr_v [2];
  logic        resp_ready_v[2];

  // observed outputs
  logic        o_ld_ready [2];
  logic        o_ld_ovf   [2];
  logic [31:0] o_cnt      [2];
  logic        o_req_ready[2];
  logic        o_resp_valid[2];
  logic [31:0] o_resp_instr[2];
  logic        o_resp_err [2];
  logic [0:0]  o_state    [2];

  logic [0:0] st_a, st_b;

  instr_mem_ctrl_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(1024)) ia ();
  instr_mem_ctrl_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4))    ib ();

  instr_mem_ctrl #(.ADDR_W(64), .INSTR_W(32), .DEPTH(1024), .BYTE_ADDR(1), .NOP(NOP)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave), .dbg_state(st_a));
  instr_mem_ctrl #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .BYTE_ADDR(0), .NOP(NOP)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave), .dbg_state(st_b));

  assign ia.ld_start = ld_start_v[0];   assign ib.ld_start = ld_start_v[1];
  assign ia.ld_valid = ld_valid_v[0];   assign ib.ld_valid = ld_valid_v[1];
  assign ia.ld_last  = ld_last_v[0];    assign ib.ld_last  = ld_last_v[1];
  assign ia.ld_data  = ld_data_v[0];    assign ib.ld_data  = ld_data_v[1];
  assign ia.req_valid = req_valid_v[0]; assign ib.req_valid = req_valid_v[1];
  assign ia.req_addr  = req_addr_v[0];  assign ib.req_addr  = req_addr_v[1];
  assign ia.resp_ready = resp_ready_v[0]; assign ib.resp_ready = resp_ready_v[1];

  assign o_ld_ready[0] = ia.ld_ready;     assign o_ld_ready[1] = ib.ld_ready;
  assign o_ld_ovf[0]   = ia.ld_ovf;       assign o_ld_ovf[1]   = ib.ld_ovf;
  assign o_cnt[0]      = 32'(ia.loaded_words); assign o_cnt[1] = 32'(ib.loaded_words);
  assign o_req_ready[0] = ia.req_ready;   assign o_req_ready[1] = ib.req_ready;
  assign o_resp_valid[0] = ia.resp_valid; assign o_resp_valid[1] = ib.resp_valid;
  assign o_resp_instr[0] = ia.resp_instr; assign o_resp_instr[1] = ib.resp_instr;
  assign o_resp_err[0] = ia.resp_err;     assign o_resp_err[1] = ib.resp_err;
  assign o_state[0] = st_a;               assign o_state[1] = st_b;

  // reference model
  int          depth_m[2] = '{1024, 4};
  bit          byte_m [2] = '{1'b1, 1'b0};
  bit          m_run [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_rv  [2];
  logic [31:0] mmem [int];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] predict(input int u, input logic [63:0] a);
    logic [63:0] idx;
    bit mis;
    int key;
    if (byte_m[u]) begin idx = a >> 2; mis = (a[1:0] != 2'b00); end
    else begin idx = a; mis = 1'b0; end
    if (mis || idx >= 64'(depth_m[u])) return {1'b1, 1'b1, NOP};
    key = u * 4096 + int'(idx);
    if (mmem.exists(key)) return {1'b1, 1'b0, mmem[key]};
    return {1'b0, 1'b0, 32'h0};
  endfunction

  task automatic set_idle(input int u);
    ld_start_v[u] = 1'b0; ld_valid_v[u] = 1'b0; ld_last_v[u] = 1'b0; ld_data_v[u] = '0;
    req_valid_v[u] = 1'b0; req_addr_v[u] = '0; resp_ready_v[u] = 1'b1;
  endtask

  // One clock: check combinational/held outputs, advance model, check registered outputs.
  task automatic tick();
    logic [W-1:0] ent, nxt;
    bit er, acc;
    #1;
    for (int u = 0; u < 2; u++) begin
      er = m_run[u] && (!m_rv[u] || resp_ready_v[u]);
      check($sformatf("u%0d_req_ready", u), 64'(o_req_ready[u]), 64'(er));
      if (m_rv[u]) begin
        if ((u == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          check($sformatf("u%0d_queue_nonempty", u), 64'(0), 64'(1));
        end else begin
          ent = (u == 0) ? exp_q0[0] : exp_q1[0];
          check($sformatf("u%0d_resp_err", u), 64'(o_resp_err[u]), 64'(ent[32]));
          if (ent[W-1]) check($sformatf("u%0d_resp_instr", u), 64'(o_resp_instr[u]), 64'(ent[31:0]));
        end
      end
      acc = req_valid_v[u] && er;
      nxt = predict(u, req_addr_v[u]);
      if (!m_run[u]) begin
        if (ld_start_v[u]) begin m_cnt[u] = 0; m_ovf[u] = 1'b0; end
        else if (ld_valid_v[u]) begin
          if (m_cnt[u] < depth_m[u]) begin
            mmem[u * 4096 + m_cnt[u]] = ld_data_v[u];
            m_cnt[u]++;
          end else m_ovf[u] = 1'b1;
          if (ld_last_v[u]) m_run[u] = 1'b1;
        end
      end else if (ld_start_v[u]) begin
        m_run[u] = 1'b0; m_cnt[u] = 0; m_ovf[u] = 1'b0;
      end
      if (m_rv[u] && resp_ready_v[u]) begin
        if (u == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      end
      if (acc) begin
        if (u == 0) exp_q0.push_back(nxt); else exp_q1.push_back(nxt);
        m_rv[u] = 1'b1;
      end else if (resp_ready_v[u]) m_rv[u] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_state", u), 64'(o_state[u]), 64'(m_run[u]));
      check($sformatf("u%0d_ld_ready", u), 64'(o_ld_ready[u]), 64'(!m_run[u]));
      check($sformatf("u%0d_ld_ovf", u), 64'(o_ld_ovf[u]), 64'(m_ovf[u]));
      check($sformatf("u%0d_loaded_words", u), 64'(o_cnt[u]), 64'(m_cnt[u]));
      check($sformatf("u%0d_resp_valid", u), 64'(o_resp_valid[u]), 64'(m_rv[u]));
    end
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear with no clock.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_rst_resp_valid", u), 64'(o_resp_valid[u]), 64'(0));
      check($sformatf("u%0d_rst_resp_instr", u), 64'(o_resp_instr[u]), 64'(0));
      check($sformatf("u%0d_rst_resp_err", u), 64'(o_resp_err[u]), 64'(0));
      check($sformatf("u%0d_rst_loaded_words", u), 64'(o_cnt[u]), 64'(0));
      check($sformatf("u%0d_rst_ld_ovf", u), 64'(o_ld_ovf[u]), 64'(0));
      check($sformatf("u%0d_rst_ld_ready", u), 64'(o_ld_ready[u]), 64'(1));
      check($sformatf("u%0d_rst_req_ready", u), 64'(o_req_ready[u]), 64'(0));
      check($sformatf("u%0d_rst_state", u), 64'(o_state[u]), 64'(0));
      m_run[u] = 1'b0; m_cnt[u] = 0; m_ovf[u] = 1'b0; m_rv[u] = 1'b0;
      set_idle(u);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_seq(input int u, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      ld_valid_v[u] = 1'b1;
      ld_data_v[u]  = base + 32'(i);
      ld_last_v[u]  = (i == n - 1);
      tick();
    end
    ld_valid_v[u] = 1'b0;
    ld_last_v[u]  = 1'b0;
  endtask

  task automatic fetch_seq(input int u, input logic [63:0] a0, input logic [63:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_v[u] = 1'b1;
      req_addr_v[u]  = a0 + step * 64'(i);
      tick();
    end
    req_valid_v[u] = 1'b0;
    tick();
  endtask

  initial begin
    set_idle(0);
    set_idle(1);
    #2;
    async_reset();

    // basic load and back-to-back byte-address fetches
    load_seq(0, 4, 32'hA0);
    check("a_loaded4", 64'(o_cnt[0]), 64'(4));
    check("a_run", 64'(o_state[0]), 64'(1));
    fetch_seq(0, 64'h0, 64'h4, 4);

    // misaligned and out-of-range
    req_valid_v[0] = 1'b1; req_addr_v[0] = 64'h6; tick();
    check("a_mis_err", 64'(o_resp_err[0]), 64'(1));
    check("a_mis_nop", 64'(o_resp_instr[0]), 64'(NOP));
    req_addr_v[0] = 64'h1000; tick();
    check("a_oor_err", 64'(o_resp_err[0]), 64'(1));
    req_addr_v[0] = 64'hFFFF_FFFF_0000_0008; tick();
    req_valid_v[0] = 1'b0; tick();

    // back-pressure: response held, no accept, then accept on release
    req_valid_v[0] = 1'b1; req_addr_v[0] = 64'h0; tick();
    resp_ready_v[0] = 1'b0; req_addr_v[0] = 64'h4;
    for (int i = 0; i < 3; i++) tick();
    check("a_hold_instr", 64'(o_resp_instr[0]), 64'h0A0);
    resp_ready_v[0] = 1'b1; tick();
    check("a_release_instr", 64'(o_resp_instr[0]), 64'h0A1);
    req_valid_v[0] = 1'b0; tick();

    // overflow on the 4-word instance, word addressing
    load_seq(1, 6, 32'hC0);
    check("b_ovf", 64'(o_ld_ovf[1]), 64'(1));
    check("b_loaded4", 64'(o_cnt[1]), 64'(4));
    fetch_seq(1, 64'h0, 64'h1, 6);

    // reload at run time with a concurrent fetch
    ld_start_v[0] = 1'b1; req_valid_v[0] = 1'b1; req_addr_v[0] = 64'h0; tick();
    ld_start_v[0] = 1'b0; req_valid_v[0] = 1'b0;
    check("a_reload_state", 64'(o_state[0]), 64'(0));
    check("a_reload_ovf", 64'(o_ld_ovf[0]), 64'(0));
    tick();
    ld_start_v[0] = 1'b1; ld_valid_v[0] = 1'b1; ld_last_v[0] = 1'b1; ld_data_v[0] = 32'hDEAD; tick();
    ld_start_v[0] = 1'b0; ld_valid_v[0] = 1'b0; ld_last_v[0] = 1'b0;
    check("a_start_beats_last", 64'(o_state[0]), 64'(0));
    load_seq(0, 1, 32'hB0);
    fetch_seq(0, 64'h0, 64'h4, 2);

    // reset mid-load (b) and with a pending response (a)
    ld_start_v[1] = 1'b1; tick();
    ld_start_v[1] = 1'b0;
    req_valid_v[0] = 1'b1; req_addr_v[0] = 64'h0; resp_ready_v[0] = 1'b0;
    ld_valid_v[1] = 1'b1; ld_data_v[1] = 32'hE0; tick();
    req_valid_v[0] = 1'b0; ld_data_v[1] = 32'hE1; tick();
    ld_valid_v[1] = 1'b0; tick();
    check("a_pending_before_rst", 64'(o_resp_valid[0]), 64'(1));
    check("b_midload_before_rst", 64'(o_cnt[1]), 64'(2));
    #3;
    async_reset();

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int u = 0; u < 2; u++) begin
        ld_start_v[u]   = ($urandom_range(0, 39) == 0);
        ld_valid_v[u]   = ($urandom_range(0, 2) != 0);
        ld_last_v[u]    = ($urandom_range(0, 9) == 0);
        ld_data_v[u]    = $urandom;
        req_valid_v[u]  = ($urandom_range(0, 3) != 0);
        resp_ready_v[u] = ($urandom_range(0, 3) != 0);
        if (u == 0) begin
          case ($urandom_range(0, 5))
            0, 1, 2: req_addr_v[0] = 64'($urandom_range(0, 31)) << 2;
            3:       req_addr_v[0] = 64'($urandom_range(0, 1023)) << 2;
            4:       req_addr_v[0] = (64'($urandom_range(0, 31)) << 2) | 64'($urandom_range(1, 3));
            default: req_addr_v[0] = {$urandom, $urandom};
          endcase
        end else begin
          if ($urandom_range(0, 4) != 0) req_addr_v[1] = 64'($urandom_range(0, 7));
          else                           req_addr_v[1] = {$urandom, $urandom};
        end
      end
      tick();
    end
    set_idle(0);
    set_idle(1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a streaming program-load port and a valid/ready fetch port. After reset it sits in a load phase and accepts a program as a stream of words. It then serves fetch requests at one-cycle latency, with back-pressure and alignment/range error reporting. It sits between the fetch stage (request side) and a boot/debug loader (load side), and can be reloaded at run time without a reset.

## Interface
- ADDR_W, 64, width of fetch byte address
- INSTR_W, 32, instruction word width
- DEPTH, 1024, number of words; power of two, ≥ 2
- BYTE_ADDR, 1, 1: req_addr is a byte address, word index = req_addr >> log2(INSTR_W/8); 0: req_addr is a word index
- NOP, 32'h00000013, value driven on resp_instr with an error response

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ld_start  in  1  pulse: restart loading at word 0
- ld_valid  in  1  load word present
- ld_data  in  INSTR_W  load word
- ld_last  in  1  qualifies final load word
- ld_ready  out  1  load port accepting (state LOAD)
- ld_ovf  out  1  sticky: words offered beyond DEPTH
- loaded_words  out  log2(DEPTH)+1  words stored by last/current load
- req_valid  in  1  fetch request
- req_addr  in  ADDR_W  fetch address
- req_ready  out  1  request accepted this cycle when high with req_valid
- resp_valid  out  1  response present
- resp_instr  out  INSTR_W  fetched instruction, or NOP on error
- resp_err  out  1  request was misaligned or out of range
- resp_ready  in  1  consumer takes response

## Operation
- States: LOAD, RUN. Reset state LOAD.
- LOAD: ld_ready=1, req_ready=0.
  - Each cycle with ld_valid=1, ld_data is written to mem[ptr] if ptr < DEPTH; ptr and loaded_words then increment.
  - If ptr = DEPTH, the word is dropped and ld_ovf is set.
  - ld_valid & ld_last → RUN next cycle; the last word is written under the same rule.
  - ld_start in LOAD → ptr=0, loaded_words=0, ld_ovf=0. It takes priority over ld_valid in the same cycle: that word is discarded.
- RUN: ld_ready=0; ld_valid ignored.
  - ld_start → LOAD next cycle; ptr, loaded_words and ld_ovf cleared.
  - A request accepted in the same cycle is served from the old contents.
  - A pending response is unaffected by the state change.
- Fetch (RUN only): req_ready = (state==RUN) && (!resp_valid || resp_ready). This is combinational from state and the output register.
- On accept, the index is formed per BYTE_ADDR.
  - err = misaligned (BYTE_ADDR=1 and low log2(INSTR_W/8) address bits ≠ 0) OR index ≥ DEPTH. The full ADDR_W bits are compared, not truncated.
  - err=0: resp_instr=mem[index], resp_err=0.
  - err=1: resp_instr=NOP, resp_err=1.
- Reads of words never written in any load return whatever the memory holds. The bench must not check them.
- Response hold: while resp_valid && !resp_ready, resp_instr and resp_err are stable and no new request is accepted.
- Memory contents are not cleared by reset or by ld_start.

## Timing
- Reset (rst=0, asynchronous): state=LOAD, ptr=0, loaded_words=0, ld_ovf=0, resp_valid=0, resp_instr=0, resp_err=0. Outputs take these values immediately, without a clock edge.
- Fetch latency 1: accept at edge N → resp_valid=1 with data after edge N. Full throughput is one per cycle while resp_ready=1.
- resp_valid clears after the edge where resp_ready=1 unless a new request is accepted at that edge.
- Load write takes effect at the accepting edge. A word written at edge N is readable by a request accepted at edge N+1 or later. This is only possible after the RUN transition.
- ld_last accepted at edge N → state=RUN after N; req_ready can be 1 in cycle N+1.
- Reset mid-load or mid-response: discard all in-flight state. resp_valid drops immediately.

## Test plan
- Reset, load 4 words (0xA0..0xA3) with ld_last on the 4th → loaded_words=4, RUN. Back-to-back byte-address fetches of 0x0, 0x4, 0x8, 0xC return 0xA0..0xA3 on consecutive cycles, resp_err=0.
- In RUN, fetch 0x6 (misaligned) and 0x1000 with DEPTH=1024 → resp_instr=0x00000013, resp_err=1 for each.
- Hold resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and resp_instr stable. On release, the next request is accepted the same cycle.
- DEPTH=4, stream 6 words, last on 6th → ld_ovf=1, loaded_words=4. Words 0..3 are intact.
- In RUN, assert ld_start with a concurrent fetch of 0x0 → old word returned, state=LOAD, ld_ovf=0. Load 0xB0 plus last → fetch 0x0 returns 0xB0.
- Drop rst mid-load and with resp_valid=1 → resp_valid=0 and loaded_words=0 immediately, state=LOAD.
